// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store unit. Accepts one memory instruction from the
//            execute stage, issues a single word-aligned bus access, and returns
//            sign/zero-extended load data. Misaligned and illegal requests fault
//            without touching the bus; a bus that never answers raises a
//            timeout fault.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            ex_*, funct3,
//            addr, store_data,
//            rd               - instruction from the execute stage
//            stall            - hold the execute stage
//            mem_*            - simple request/ready memory bus
//            wb_*             - load writeback (one-cycle pulse)
//            fault*           - one-cycle fault pulse with code and address
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_FC_MISALIGN = 2'b01;
    localparam logic [1:0] c_FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] c_FC_TIMEOUT  = 2'b11;

    // ------------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic [31:0]        r_store_data;
    logic [4:0]         r_rd;
    logic               r_is_load;
    logic [c_CNT_W-1:0] r_timer;
    logic [31:0]        r_wb_data;
    logic               r_fault;
    logic [1:0]         r_fault_code;
    logic [31:0]        r_fault_addr;

    // ------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    logic w_req;
    logic w_illegal;
    logic w_misalign;
    logic w_accept;
    logic w_fault_in;
    logic w_bus_done;
    logic w_timeout;

    always_comb begin
        w_req      = ex_valid & (ex_is_load | ex_is_store);

        // funct3 = 3 (LD/SD) is RV64 only; 6/7 have no load meaning; any
        // store above SW is undefined. Dual kind bits are malformed decode.
        w_illegal  = (ex_is_load & ex_is_store)
                   | (ex_is_load  & ((funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7)))
                   | (ex_is_store & (funct3 >= 3'd3));

        // Size is funct3[1:0]; illegal encodings take priority over this.
        w_misalign = ((funct3[1:0] == 2'b01) & addr[0])
                   | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

        w_accept   = (r_state == c_ST_IDLE) & w_req & ~w_illegal & ~w_misalign;
        w_fault_in = (r_state == c_ST_IDLE) & w_req & (w_illegal | w_misalign);

        w_bus_done = (r_state == c_ST_BUS) & mem_ready;
        // A ready arriving on the last allowed cycle still completes normally.
        w_timeout  = (r_state == c_ST_BUS) & ~mem_ready & (r_timer == c_CNT_LAST);
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_BUS;
            c_ST_BUS: begin
                if (w_bus_done)     w_state_nxt = c_ST_DONE;
                else if (w_timeout) w_state_nxt = c_ST_IDLE;
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
        end else if (w_accept) begin
            r_addr       <= addr;
            r_funct3     <= funct3;
            r_store_data <= store_data;
            r_rd         <= rd;
            r_is_load    <= ex_is_load;
        end
    end

    // Counts BUS cycles that ended without mem_ready; cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                   r_timer <= '0;
        else if ((r_state == c_ST_BUS) & ~mem_ready & ~w_timeout) r_timer <= r_timer + 1'b1;
        else                                                       r_timer <= '0;
    end

    // ------------------------------------------------------------------------
    // Load lane extraction from the bus word
    // ------------------------------------------------------------------------
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_ext;

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_lane_byte = mem_rdata[7:0];
            2'd1:    w_lane_byte = mem_rdata[15:8];
            2'd2:    w_lane_byte = mem_rdata[23:16];
            default: w_lane_byte = mem_rdata[31:24];
        endcase
        w_lane_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b001:  w_load_ext = {{16{w_lane_half[15]}}, w_lane_half};
            3'b100:  w_load_ext = {24'd0, w_lane_byte};
            3'b101:  w_load_ext = {16'd0, w_lane_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_wb_data <= '0;
        else if (w_bus_done) r_wb_data <= w_load_ext;
    end

    // ------------------------------------------------------------------------
    // Fault pulse: registered so it appears the cycle after the cause
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_fault_addr <= '0;
        end else if (w_timeout) begin
            r_fault      <= 1'b1;
            r_fault_code <= c_FC_TIMEOUT;
            r_fault_addr <= r_addr;
        end else if (w_fault_in) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_illegal ? c_FC_ILLEGAL : c_FC_MISALIGN;
            r_fault_addr <= addr;
        end else begin
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_fault_addr <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Store lane encoding
    // ------------------------------------------------------------------------
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;

    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{r_store_data[7:0]}};
                w_st_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{r_store_data[15:0]}};
                w_st_wstrb = 4'b0011 << r_addr[1:0];
            end
            default: begin
                w_st_wdata = r_store_data;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. Everything is decoded from registered state so that an
    // asynchronous reset clears the outputs without waiting for a clock.
    // Loads drive zero write data and strobes.
    // ------------------------------------------------------------------------
    logic w_in_bus;
    logic w_wb_now;

    always_comb begin
        w_in_bus   = (r_state == c_ST_BUS);
        w_wb_now   = (r_state == c_ST_DONE) & r_is_load;

        // rst gates the accept term: a request seen while reset is held is
        // discarded, so it must not stall the pipeline.
        stall      = ~rst & (w_accept | w_in_bus);

        mem_req    = w_in_bus;
        mem_we     = w_in_bus & ~r_is_load;
        mem_addr   = w_in_bus ? {r_addr[31:2], 2'b00} : 32'd0;
        mem_wdata  = (w_in_bus & ~r_is_load) ? w_st_wdata : 32'd0;
        mem_wstrb  = (w_in_bus & ~r_is_load) ? w_st_wstrb : 4'd0;

        wb_valid   = w_wb_now;
        wb_rd      = w_wb_now ? r_rd : 5'd0;
        wb_data    = w_wb_now ? r_wb_data : 32'd0;

        fault      = r_fault;
        fault_code = r_fault_code;
        fault_addr = r_fault_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A transaction-level
//            model predicts every output each cycle; directed cases pin the
//            model with hand-computed values, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        stall, mem_req, mem_we, wb_valid, fault;
    logic [31:0] mem_addr, mem_wdata, wb_data, fault_addr;
    logic [3:0]  mem_wstrb;
    logic [4:0]  wb_rd;
    logic [1:0]  fault_code;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_code(fault_code), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------------
    bit          m_busy, m_done, m_flt;      // access in flight / completion cycle / fault pulse
    int          m_wait;                     // bus cycles elapsed without ready
    bit          t_load;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_data, m_wbdata, m_faddr;
    logic [4:0]  t_rd;
    logic [1:0]  m_fcode;

    logic        e_stall, e_req, e_we, e_wbv, e_flt;
    logic [31:0] e_maddr, e_wdata, e_wbdata, e_faddr;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_wbrd;
    logic [1:0]  e_fcode;

    // 0 = accept, 1 = misaligned, 2 = illegal
    function automatic int classify(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [31:0] a);
        int size;
        if (ld && st) return 2;
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 2;
        if (st && f3 >= 3) return 2;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 1;
        return 0;
    endfunction

    // Each byte lane carries data byte (lane mod size): replication falls out.
    function automatic logic [31:0] enc_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int size;
        size = 1 << f3[1:0];
        w = '0;
        for (int lane = 0; lane < 4; lane++) w[lane*8 +: 8] = d[(lane % size)*8 +: 8];
        return w;
    endfunction

    function automatic logic [3:0] enc_wstrb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int size, off;
        size = 1 << f3[1:0];
        off  = a % 4;
        s = '0;
        for (int lane = 0; lane < 4; lane++) s[lane] = (lane >= off) && (lane < off + size);
        return s;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
        logic [31:0] v;
        int size;
        size = 1 << f3[1:0];
        v = w >> (8 * (a % 4));
        if (size == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_flt = 0; m_wait = 0;
        t_load = 0; t_f3 = '0; t_addr = '0; t_data = '0; t_rd = '0;
        m_wbdata = '0; m_faddr = '0; m_fcode = '0;
    endtask

    // Expected outputs for the current cycle given model state and inputs.
    task automatic model_expect();
        bit req;
        req      = ex_valid && (ex_is_load || ex_is_store);
        e_req    = m_busy;
        e_we     = m_busy && !t_load;
        e_maddr  = m_busy ? (t_addr & ~32'd3) : 32'd0;
        e_wdata  = (m_busy && !t_load) ? enc_wdata(t_f3, t_data) : 32'd0;
        e_wstrb  = (m_busy && !t_load) ? enc_wstrb(t_f3, t_addr) : 4'd0;
        e_stall  = m_busy || (!m_done && req && classify(ex_is_load, ex_is_store, funct3, addr) == 0);
        e_wbv    = m_done && t_load;
        e_wbrd   = e_wbv ? t_rd : 5'd0;
        e_wbdata = e_wbv ? m_wbdata : 32'd0;
        e_flt    = m_flt;
        e_fcode  = m_flt ? m_fcode : 2'd0;
        e_faddr  = m_flt ? m_faddr : 32'd0;
    endtask

    // Advance the model across one rising edge.
    task automatic model_update();
        bit nf, nd;
        int k;
        nf = 0; nd = 0;
        if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0; nd = 1;
                m_wbdata = extract(t_f3, t_addr, mem_rdata);
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_busy = 0; nf = 1; m_fcode = 2'b11; m_faddr = t_addr;
                end
            end
        end else if (!m_done && ex_valid && (ex_is_load || ex_is_store)) begin
            k = classify(ex_is_load, ex_is_store, funct3, addr);
            if (k == 0) begin
                m_busy = 1; m_wait = 0;
                t_load = ex_is_load; t_f3 = funct3; t_addr = addr; t_data = store_data; t_rd = rd;
            end else begin
                nf = 1; m_fcode = 2'(k); m_faddr = addr;
            end
        end
        m_done = nd;
        m_flt  = nf;
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("stall",      {31'd0, stall},    {31'd0, e_stall});
            chk("mem_req",    {31'd0, mem_req},  {31'd0, e_req});
            chk("mem_we",     {31'd0, mem_we},   {31'd0, e_we});
            chk("mem_addr",   mem_addr,          e_maddr);
            chk("mem_wdata",  mem_wdata,         e_wdata);
            chk("mem_wstrb",  {28'd0, mem_wstrb}, {28'd0, e_wstrb});
            chk("wb_valid",   {31'd0, wb_valid}, {31'd0, e_wbv});
            chk("wb_rd",      {27'd0, wb_rd},    {27'd0, e_wbrd});
            chk("wb_data",    wb_data,           e_wbdata);
            chk("fault",      {31'd0, fault},    {31'd0, e_flt});
            chk("fault_code", {30'd0, fault_code}, {30'd0, e_fcode});
            chk("fault_addr", fault_addr,        e_faddr);
            chk("fault_and_wb", {31'd0, fault & wb_valid}, 32'd0);
        end
    end

    // ------------------------------------------------------------------------
    // Driving helpers: inputs change 1ns after the rising edge
    // ------------------------------------------------------------------------
    task automatic set_in(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                          input bit rdy, input logic [31:0] rdat);
        ex_valid = v; ex_is_load = ld; ex_is_store = st; funct3 = f3;
        addr = a; store_data = d; rd = r; mem_ready = rdy; mem_rdata = rdat;
        model_expect();
    endtask

    task automatic idle_in(input bit rdy, input logic [31:0] rdat);
        set_in(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, rdy, rdat);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    int cnt;
    bit seen;

    initial begin
        model_reset();
        idle_in(0, 0);
        repeat (2) @(posedge clk);
        #2;
        // Reset state
        chk("rst_stall",   {31'd0, stall},   32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wb",      {31'd0, wb_valid}, 32'd0);
        chk("rst_fault",   {31'd0, fault},   32'd0);
        chk("rst_maddr",   mem_addr,         32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // LB 0x1003 -> sign-extended 0x80
        set_in(1, 1, 0, 3'd0, 32'h1003, 32'd0, 5'd5, 0, 32'd0);
        #1 chk("lb_accept_stall", {31'd0, stall}, 32'd1);
        step();
        set_in(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 32'h80FF_0000);
        #1 chk("lb_mem_addr", mem_addr, 32'h0000_1000);
        chk("lb_mem_we", {31'd0, mem_we}, 32'd0);
        chk("lb_mem_req", {31'd0, mem_req}, 32'd1);
        step();
        idle_in(0, 0);
        #1 chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'd0, wb_rd}, 32'd5);
        step();

        // SH 0x2002 with one wait cycle
        set_in(1, 0, 1, 3'd1, 32'h2002, 32'h1234_ABCD, 5'd0, 0, 32'd0);
        step();
        idle_in(0, 32'd0);
        #1 chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        chk("sh_stall_wait", {31'd0, stall}, 32'd1);
        step();
        idle_in(1, 32'hDEAD_BEEF);
        #1 chk("sh_stall_ready", {31'd0, stall}, 32'd1);
        step();
        idle_in(0, 0);
        #1 chk("sh_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("sh_done_stall", {31'd0, stall}, 32'd0);
        step();

        // LW 0x3001 misaligned
        set_in(1, 1, 0, 3'd2, 32'h3001, 32'd0, 5'd7, 0, 32'd0);
        #1 chk("lw_mis_stall", {31'd0, stall}, 32'd0);
        step();
        idle_in(1, 0);
        #1 chk("lw_mis_fault", {31'd0, fault}, 32'd1);
        chk("lw_mis_code", {30'd0, fault_code}, 32'd1);
        chk("lw_mis_addr", fault_addr, 32'h0000_3001);
        chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
        step();

        // Both kind bits -> illegal
        set_in(1, 1, 1, 3'd2, 32'h100, 32'd0, 5'd1, 0, 32'd0);
        step();
        idle_in(0, 0);
        #1 chk("both_code", {30'd0, fault_code}, 32'd2);
        chk("both_req", {31'd0, mem_req}, 32'd0);
        step();
        // Load funct3=3 -> illegal
        set_in(1, 1, 0, 3'd3, 32'h200, 32'd0, 5'd1, 0, 32'd0);
        step();
        idle_in(0, 0);
        #1 chk("ld3_code", {30'd0, fault_code}, 32'd2);
        step();

        // LHU 0x4000 with ready never asserted -> timeout
        set_in(1, 1, 0, 3'd5, 32'h4000, 32'd0, 5'd9, 0, 32'd0);
        step();
        cnt = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            idle_in(0, 32'hFFFF_FFFF);
            #1;
            if (!mem_req) begin
                chk("to_fault", {31'd0, fault}, 32'd1);
                chk("to_code", {30'd0, fault_code}, 32'd3);
                chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
                seen = 1;
                break;
            end
            cnt++;
            step();
        end
        chk("to_seen", {31'd0, seen}, 32'd1);
        chk("to_req_cycles", cnt, TIMEOUT);
        step();

        // Reset during a store's bus phase
        set_in(1, 0, 1, 3'd2, 32'h5004, 32'h0BAD_F00D, 5'd0, 0, 32'd0);
        step();
        idle_in(0, 0);
        #1 chk("rb_req_before", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("rb_req_async", {31'd0, mem_req}, 32'd0);
        chk("rb_stall_async", {31'd0, stall}, 32'd0);
        chk("rb_we_async", {31'd0, mem_we}, 32'd0);
        model_reset();
        idle_in(0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_in(1, 1, 0, 3'd2, 32'h6000, 32'd0, 5'd12, 0, 32'd0);
        step();
        idle_in(1, 32'hCAFE_1234);
        step();
        idle_in(0, 0);
        #1 chk("rb_ld_wb", {31'd0, wb_valid}, 32'd1);
        chk("rb_ld_data", wb_data, 32'hCAFE_1234);
        step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit v, ld, st, rdy;
            int k;
            logic [2:0] f3;
            v = ($urandom_range(0, 99) < 70);
            k = $urandom_range(0, 19);
            ld = (k < 9) || (k == 18);
            st = (k >= 9 && k < 19);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (ld && !st) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else f3 = 3'($urandom_range(0, 2));
            rdy = ($urandom_range(0, 2) == 0);
            set_in(v, ld, st, f3, $urandom, $urandom, 5'($urandom), rdy, $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
